// File: rtl/gray_ipu_stream.sv
// Streaming grayscale unit: converts RGB pixels one per handshake and packs
// PIX_PER_WORD gray samples into memory-width words for a fixed-length frame.

module gray_ipu_pixel #(
    parameter int CH_W = 8
) (
    input  logic [1:0]        mode,
    input  logic [CH_W-1:0]   thresh,
    input  logic [3*CH_W-1:0] rgb,
    output logic [CH_W-1:0]   gray
);
    localparam int ACC_W = CH_W + 10;

    logic [CH_W-1:0] r, g, b;
    logic [CH_W-1:0] luma, mean;

    assign r = rgb[3*CH_W-1:2*CH_W];
    assign g = rgb[2*CH_W-1:CH_W];
    assign b = rgb[CH_W-1:0];

    // Luma weights sum to 256, so the shifted result never exceeds the channel maximum
    assign luma = CH_W'((ACC_W'(r) * ACC_W'(77) + ACC_W'(g) * ACC_W'(150)
                       + ACC_W'(b) * ACC_W'(29)) >> 8);
    assign mean = CH_W'((ACC_W'(r) + ACC_W'(g) + ACC_W'(b)) / ACC_W'(3));

    always_comb begin
        gray = '0;
        case (mode)
            2'd0: gray = luma;
            2'd1: gray = mean;
            2'd2: gray = (luma >= thresh) ? '1 : '0;
            2'd3: gray = g;
        endcase
    end
endmodule

module gray_ipu_stream #(
    parameter int CH_W         = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int NUM_PIX      = 64,
    parameter int WIDX_W       = ((NUM_PIX / PIX_PER_WORD) > 1) ? $clog2(NUM_PIX / PIX_PER_WORD) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [CH_W-1:0]              thresh,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3*CH_W-1:0]            in_rgb,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PIX_PER_WORD*CH_W-1:0] out_word,
    output logic [WIDX_W-1:0]            out_index,
    output logic [CH_W-1:0]              gray_last,
    output logic                         busy,
    output logic                         done
);
    localparam int LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int PIX_W  = $clog2(NUM_PIX + 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(NUM_PIX - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                        state;
    logic [1:0]                    mode_q;
    logic [CH_W-1:0]               thresh_q;
    logic [LANE_W-1:0]             lane_cnt;
    logic [PIX_W-1:0]              pix_cnt;
    logic [WIDX_W-1:0]             word_cnt;
    logic [PIX_PER_WORD*CH_W-1:0]  pack_reg;
    logic [PIX_PER_WORD*CH_W-1:0]  pack_next;
    logic [CH_W-1:0]               g_cur;
    logic                          accept;
    logic                          out_hs;
    logic [WIDX_W-1:0]             next_index;

    gray_ipu_pixel #(.CH_W(CH_W)) u_pixel (
        .mode   (mode_q),
        .thresh (thresh_q),
        .rgb    (in_rgb),
        .gray   (g_cur)
    );

    // A pending word blocks input unless it is being taken this same cycle
    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    // A word completing alongside the previous handshake takes the next index
    assign next_index = out_hs ? (word_cnt + WIDX_W'(1)) : word_cnt;

    always_comb begin
        pack_next = pack_reg;
        pack_next[int'(lane_cnt) * CH_W +: CH_W] = g_cur;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            mode_q    <= '0;
            thresh_q  <= '0;
            lane_cnt  <= '0;
            pix_cnt   <= '0;
            word_cnt  <= '0;
            pack_reg  <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_index <= '0;
            gray_last <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (out_hs) begin
                out_valid <= 1'b0;
                word_cnt  <= word_cnt + WIDX_W'(1);
            end

            if (accept) begin
                gray_last <= g_cur;
                pix_cnt   <= pix_cnt + PIX_W'(1);
                if (lane_cnt == LAST_LANE) begin
                    lane_cnt  <= '0;
                    pack_reg  <= '0;
                    out_valid <= 1'b1;
                    out_word  <= pack_next;
                    out_index <= next_index;
                end else begin
                    lane_cnt <= lane_cnt + LANE_W'(1);
                    pack_reg <= pack_next;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        mode_q   <= mode;
                        thresh_q <= thresh;
                        lane_cnt <= '0;
                        pix_cnt  <= '0;
                        word_cnt <= '0;
                        pack_reg <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept && (pix_cnt == LAST_PIX)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_hs) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gray_ipu_stream.sv
// Scoreboard bench for gray_ipu_stream: the driver pushes expected words from a
// plain-arithmetic reference model, and a negedge monitor pops them on handshakes.

module tb_gray_ipu_stream;
    localparam int CH_W    = 8;
    localparam int PPW     = 4;
    localparam int NUM_PIX = 64;
    localparam int WIDX_W  = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [1:0]          mode;
    logic [CH_W-1:0]     thresh;
    logic                in_valid;
    logic                in_ready;
    logic [3*CH_W-1:0]   in_rgb;
    logic                out_valid;
    logic                out_ready;
    logic [PPW*CH_W-1:0] out_word;
    logic [WIDX_W-1:0]   out_index;
    logic [CH_W-1:0]     gray_last;
    logic                busy;
    logic                done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_hs_cyc = -100;
    bit ready_rand = 1'b0;

    typedef struct packed {
        logic [31:0] word;
        logic [3:0]  idx;
    } exp_t;
    exp_t exp_q[$];

    logic [1:0]  m_mode;
    logic [7:0]  m_thresh;
    int          m_lane;
    logic [31:0] m_pack;
    int          m_widx;
    logic [7:0]  m_glast;

    gray_ipu_stream #(
        .CH_W(CH_W), .PIX_PER_WORD(PPW), .NUM_PIX(NUM_PIX), .WIDX_W(WIDX_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .thresh    (thresh),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rgb    (in_rgb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_index (out_index),
        .gray_last (gray_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] refGray(input logic [1:0] md, input logic [7:0] th,
                                           input logic [23:0] px);
        int r, g, b, luma;
        r = int'(px[23:16]);
        g = int'(px[15:8]);
        b = int'(px[7:0]);
        luma = (77 * r + 150 * g + 29 * b) / 256;
        case (md)
            2'd0:    return 8'(luma);
            2'd1:    return 8'((r + g + b) / 3);
            2'd2:    return (luma >= int'(th)) ? 8'hFF : 8'h00;
            default: return 8'(g);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endtask

    task automatic modelAccept(input logic [23:0] px);
        logic [7:0] gv;
        exp_t e;
        gv = refGray(m_mode, m_thresh, px);
        m_glast = gv;
        m_pack[m_lane * 8 +: 8] = gv;
        m_lane++;
        if (m_lane == PPW) begin
            e.word = m_pack;
            e.idx  = 4'(m_widx);
            exp_q.push_back(e);
            m_widx++;
            m_lane = 0;
            m_pack = '0;
        end
    endtask

    // Every driver task starts and ends just after a rising edge
    task automatic applyStimulus(input logic [23:0] px, input int gap, input logic st);
        int waitc;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_rgb   = px;
        start    = st;
        waitc    = 0;
        @(negedge clk);
        while (!in_ready && waitc < 500) begin
            waitc++;
            @(negedge clk);
        end
        if (!in_ready) begin
            reportFail("accept_timeout");
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            start    = 1'b0;
            return;
        end
        modelAccept(px);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
        checkOutput("gray_last", gray_last, m_glast);
    endtask

    task automatic runRandom(input int n, input int maxgap, input int start_at);
        for (int i = 0; i < n; i++) begin
            applyStimulus(24'($urandom), int'($urandom_range(0, maxgap)), i == start_at);
        end
    endtask

    task automatic startFrame(input logic [1:0] md, input logic [7:0] th);
        start  = 1'b1;
        mode   = md;
        thresh = th;
        m_mode = md;
        m_thresh = th;
        m_lane = 0;
        m_widx = 0;
        m_pack = '0;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mode   = ~md;
        thresh = ~th;
        checkOutput("busy_after_start", busy, 1);
    endtask

    task automatic finishFrame();
        int waitc = 0;
        @(negedge clk);
        while (!done && waitc < 1000) begin
            waitc++;
            @(negedge clk);
        end
        checkOutput("done_seen", done, 1);
        checkOutput("done_after_last_hs", cyc - last_hs_cyc, 1);
        checkOutput("busy_in_done", busy, 0);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
        checkOutput("done_pulse_len", done, 0);
        checkOutput("busy_idle", busy, 0);
    endtask

    // Monitor: each observed output handshake retires the oldest expected word
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                reportFail("unexpected_word");
            end else begin
                e = exp_q.pop_front();
                checkOutput("out_word", out_word, e.word);
                checkOutput("out_index", out_index, e.idx);
            end
            last_hs_cyc = cyc;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (ready_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t0;
        reset = 1'b1; start = 1'b0; mode = '0; thresh = '0;
        in_valid = 1'b0; in_rgb = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_word", out_word, 0);
        checkOutput("rst_out_index", out_index, 0);
        checkOutput("rst_gray_last", gray_last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        reset = 1'b0;

        $display("[TB] frame 1: luma on primaries");
        startFrame(2'd0, 8'h00);
        applyStimulus(24'hFF0000, 0, 1'b0);
        applyStimulus(24'h00FF00, 0, 1'b0);
        applyStimulus(24'h0000FF, 0, 1'b0);
        applyStimulus(24'hFFFFFF, 0, 1'b0);
        checkOutput("luma_valid", out_valid, 1);
        checkOutput("luma_word", out_word, 32'hFF1C954C);
        checkOutput("luma_index", out_index, 0);
        checkOutput("luma_gray_last", gray_last, 8'hFF);
        runRandom(NUM_PIX - 4, 1, -1);
        finishFrame();

        $display("[TB] frame 2: mean");
        startFrame(2'd1, 8'h00);
        repeat (4) applyStimulus(24'h102030, 0, 1'b0);
        checkOutput("mean_word", out_word, 32'h20202020);
        applyStimulus(24'h010101, 0, 1'b0);
        checkOutput("mean_small", gray_last, 8'h01);
        runRandom(NUM_PIX - 5, 1, -1);
        finishFrame();

        $display("[TB] frame 3: threshold and backpressure");
        startFrame(2'd2, 8'h80);
        applyStimulus(24'h808080, 0, 1'b0);
        applyStimulus(24'h7F7F7F, 0, 1'b0);
        applyStimulus(24'hFFFFFF, 0, 1'b0);
        applyStimulus(24'h000000, 0, 1'b0);
        checkOutput("thresh_word", out_word, 32'h00FF00FF);
        runRandom(4, 0, -1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_word_stable", out_word, exp_q[0].word);
            checkOutput("bp_index_stable", out_index, exp_q[0].idx);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        ready_rand = 1'b1;
        runRandom(NUM_PIX - 8, 2, -1);
        finishFrame();
        ready_rand = 1'b0;
        out_ready  = 1'b1;

        $display("[TB] frame 4: full-rate frame with ignored start");
        startFrame(2'($urandom_range(0, 3)), 8'($urandom));
        t0 = cyc;
        runRandom(NUM_PIX, 0, 20);
        checkOutput("full_rate_cycles", cyc - t0, NUM_PIX);
        finishFrame();
        @(posedge clk);
        #1;
        checkOutput("no_restart", busy, 0);

        $display("[TB] frame 5: reset mid-frame");
        startFrame(2'($urandom_range(0, 3)), 8'($urandom));
        runRandom(6, 0, -1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_out_word", out_word, 0);
        checkOutput("midrst_out_index", out_index, 0);
        checkOutput("midrst_gray_last", gray_last, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        startFrame(2'd3, 8'h00);
        applyStimulus(24'h001100, 0, 1'b0);
        applyStimulus(24'h002200, 0, 1'b0);
        applyStimulus(24'h003300, 0, 1'b0);
        applyStimulus(24'h004400, 0, 1'b0);
        checkOutput("post_rst_index", out_index, 0);
        checkOutput("post_rst_word", out_word, 32'h44332211);
        runRandom(NUM_PIX - 4, 1, -1);
        finishFrame();

        $display("[TB] random frames");
        for (int f = 0; f < 3; f++) begin
            ready_rand = 1'b1;
            startFrame(2'($urandom_range(0, 3)), 8'($urandom));
            runRandom(NUM_PIX, 3, -1);
            finishFrame();
            ready_rand = 1'b0;
            out_ready  = 1'b1;
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
